// File: rtl/fpu_pkg.sv
// Shared FPU definitions: binary32 field widths, bias and the
// stage bundles of the integer-to-float pipeline.
package fpu_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_BIAS  = 127;

    // Exponent of a value whose hidden one sits at integer bit 31.
    localparam int INT2F_EXP_BASE = FP_BIAS + 31;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W-1:0] man;
    } fp32_t;

    typedef struct packed {
        logic        sign;
        logic [31:0] mag;
    } i2f_s1_t;

    typedef struct packed {
        logic                sign;
        logic                zero;
        logic [FP_EXP_W-1:0] exp;
        logic [30:0]         norm;
    } i2f_s2_t;

endpackage

// File: rtl/itof_pipe_lzc32.sv
// Combinational leading-zero counter for a 32-bit word.
// Returns 32 for an all-zero input.
module lzc32 (
    input  logic [31:0] in,
    output logic [5:0]  cnt
);

    always_comb begin
        cnt = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (in[i]) begin
                cnt = 6'(31 - i);
            end
        end
    end

endmodule

// File: rtl/itof_pipe.sv
// Three-stage signed int32 to binary32 converter with
// valid/ready handshakes on both sides.
import fpu_pkg::*;

module itof_pipe #(
    parameter int TIES_EVEN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] s,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] d
);

    logic v1_q;
    logic v2_q;
    logic v3_q;
    logic load1;
    logic load2;
    logic load3;

    i2f_s1_t s1_q;
    i2f_s1_t s1_d;
    i2f_s2_t s2_q;
    i2f_s2_t s2_d;
    fp32_t   d_q;
    fp32_t   d_d;

    logic [5:0]          lz;
    logic [FP_MAN_W-1:0] man;
    logic [FP_MAN_W-1:0] man_r;
    logic                guard;
    logic                sticky;
    logic                rnd_up;
    logic                carry;

    // A stage refills when empty or when its content moves on.
    assign load3     = ~v3_q | out_ready;
    assign load2     = ~v2_q | load3;
    assign load1     = ~v1_q | load2;
    assign in_ready  = load1;
    assign out_valid = v3_q;
    assign d         = d_q;

    always_comb begin
        s1_d      = '0;
        s1_d.sign = s[31];
        s1_d.mag  = s[31] ? -s : s;
    end

    lzc32 u_lzc (
        .in  (s1_q.mag),
        .cnt (lz)
    );

    always_comb begin
        s2_d      = '0;
        s2_d.sign = s1_q.sign;
        s2_d.zero = (s1_q.mag == 32'd0);
        s2_d.exp  = 8'(INT2F_EXP_BASE) - {2'b00, lz};
        s2_d.norm = 31'(s1_q.mag << lz);
    end

    always_comb begin
        man    = s2_q.norm[30:8];
        guard  = s2_q.norm[7];
        sticky = |s2_q.norm[6:0];
        if (TIES_EVEN != 0) begin
            rnd_up = guard & (sticky | man[0]);
        end else begin
            rnd_up = guard;
        end
        {carry, man_r} = {1'b0, man} + 24'(rnd_up);
        d_d = '0;
        if (!s2_q.zero) begin
            d_d.sign = s2_q.sign;
            d_d.exp  = s2_q.exp + 8'(carry);
            d_d.man  = man_r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            d_q  <= '0;
        end else begin
            if (load1) v1_q <= in_valid;
            if (load2) v2_q <= v1_q;
            if (load3) v3_q <= v2_q;
            if (load3 && v2_q) d_q <= d_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load1 && in_valid) s1_q <= s1_d;
        if (load2 && v1_q) s2_q <= s2_d;
    end

endmodule

// File: tb/tb_itof_pipe.sv
// Directed bench for itof_pipe: latency, rounding corners,
// streaming, backpressure and mid-flight reset.
module tb_itof_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] d;
    logic        in_ready0;
    logic        out_valid0;
    logic [31:0] d0;

    int checks   = 0;
    int failures = 0;
    int nout;
    logic [31:0] expq[$];
    logic [31:0] sv[8];
    logic [31:0] ev[8];

    always #5 clk = ~clk;

    itof_pipe #(.TIES_EVEN(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d)
    );

    itof_pipe #(.TIES_EVEN(0)) dut_away (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .s         (s),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .d         (d0)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Single transfer; measure cycles until out_valid, check d.
    task automatic one(input string tag,
                       input logic [31:0] val,
                       input logic [31:0] exp,
                       input logic [31:0] exp_away);
        int n;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        s         = val;
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
        end
        chk({tag, "_latency"}, n, 32'd3);
        chk({tag, "_d"}, d, exp);
        chk({tag, "_d_away"}, d0, exp_away);
    endtask

    // One handshake cycle with a scoreboard of hand-made values.
    task automatic step(input logic iv,
                        input logic [31:0] val,
                        input logic [31:0] ex,
                        input logic ordy);
        @(posedge clk); #1;
        in_valid  = iv;
        s         = val;
        out_ready = ordy;
        @(negedge clk);
        if (out_valid && out_ready) begin
            nout++;
            if (expq.size() == 0) begin
                chk("sb_extra", d, 32'hDEAD_BEEF);
            end else begin
                chk("sb_data", d, expq.pop_front());
            end
        end
        if (in_valid && in_ready) expq.push_back(ex);
    endtask

    initial begin
        sv[0] = 32'd3;           ev[0] = 32'h4040_0000;
        sv[1] = 32'd4;           ev[1] = 32'h4080_0000;
        sv[2] = -32'sd2;         ev[2] = 32'hC000_0000;
        sv[3] = 32'd10;          ev[3] = 32'h4120_0000;
        sv[4] = 32'd100;         ev[4] = 32'h42C8_0000;
        sv[5] = -32'sd100;       ev[5] = 32'hC2C8_0000;
        sv[6] = 32'd255;         ev[6] = 32'h437F_0000;
        sv[7] = 32'd1024;        ev[7] = 32'h4480_0000;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        s         = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_d", d, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        one("zero",  32'd0,          32'h0000_0000, 32'h0000_0000);
        one("one",   32'd1,          32'h3F80_0000, 32'h3F80_0000);
        one("m_one", 32'hFFFF_FFFF,  32'hBF80_0000, 32'hBF80_0000);
        one("two",   32'd2,          32'h4000_0000, 32'h4000_0000);
        one("tie",   32'd16777217,   32'h4B80_0000, 32'h4B80_0001);
        one("rup",   32'd16777219,   32'h4B80_0002, 32'h4B80_0002);
        one("max",   32'h7FFF_FFFF,  32'h4F00_0000, 32'h4F00_0000);
        one("min",   32'h8000_0000,  32'hCF00_0000, 32'hCF00_0000);
        one("neg24", 32'hFF00_0001,  32'hCB7F_FFFF, 32'hCB7F_FFFF);

        // Back-to-back stream, consumer always ready.
        nout = 0;
        expq.delete();
        for (int i = 0; i < 11; i++) begin
            if (i < 8) step(1'b1, sv[i], ev[i], 1'b1);
            else       step(1'b0, 32'd0, 32'd0, 1'b1);
            if (i >= 3) begin
                chk("stream_valid", {31'd0, out_valid}, 32'd1);
            end
        end
        chk("stream_count", nout, 32'd8);
        chk("stream_left", expq.size(), 32'd0);
        step(1'b0, 32'd0, 32'd0, 1'b1);
        chk("stream_idle", {31'd0, out_valid}, 32'd0);

        // Backpressure: consumer stalls five cycles.
        nout = 0;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) step(1'b1, sv[i], ev[i], 1'b0);
            else       step(1'b1, sv[3], ev[3], 1'b0);
            if (i == 2) begin
                chk("bp_ready_open", {31'd0, in_ready}, 32'd1);
            end
            if (i >= 3) begin
                chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
                chk("bp_valid", {31'd0, out_valid}, 32'd1);
                chk("bp_hold", d, ev[0]);
            end
        end
        step(1'b1, sv[3], ev[3], 1'b1);
        chk("bp_ready_comb", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'd0, 32'd0, 1'b1);
        end
        chk("bp_count", nout, 32'd4);
        chk("bp_left", expq.size(), 32'd0);

        // Reset with two items in flight.
        step(1'b1, sv[4], ev[4], 1'b1);
        step(1'b1, sv[5], ev[5], 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        expq.delete();
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        repeat (3) @(negedge clk);
        chk("mid_rst_flush", {31'd0, out_valid}, 32'd0);
        one("after_rst", 32'd7, 32'h40E0_0000, 32'h40E0_0000);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
